// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide RAM, with sub-word
// stores done as read-modify-write and misaligned/out-of-range requests faulted.
module load_store_unit #(
  parameter int unsigned SIZE_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [1:0]  request_size,
  input  logic        request_unsigned,
  input  logic [31:0] request_address,
  input  logic [31:0] request_data,
  output logic        response_valid,
  output logic        response_error,
  output logic [31:0] response_data,
  output logic [31:0] ram_address,
  output logic [31:0] ram_input_data,
  output logic        ram_should_write,
  input  logic [31:0] ram_output_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_data_q;
  logic [31:0] ram_wdata_q;
  logic        ram_we_q;

  logic        misaligned;
  logic        out_of_range;
  logic [4:0]  lane_shift;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] load_value_d;
  logic [31:0] merged_d;

  assign misaligned   = ((request_size == 2'b01) && request_address[0]) ||
                        (request_size[1] && (request_address[1:0] != 2'b00));
  assign out_of_range = {2'b00, request_address[31:2]} >= SIZE_WORDS;

  // Halfwords are 2-byte aligned, so byte-granular shifting also selects them.
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign shifted    = ram_output_data >> lane_shift;
  assign lane_mask  = (size_q == 2'b00) ? (32'h0000_00FF << lane_shift)
                                        : (32'h0000_FFFF << lane_shift);
  assign merged_d   = (ram_output_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

  always_comb begin
    load_value_d = ram_output_data;
    case (size_q)
      2'b00:   load_value_d = unsigned_q ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_value_d = unsigned_q ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_value_d = ram_output_data;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= 32'h0;
      ram_wdata_q  <= 32'h0;
      ram_we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_data_q  <= 32'h0;
          if (request_valid) begin
            write_q    <= request_write;
            size_q     <= request_size;
            unsigned_q <= request_unsigned;
            addr_q     <= request_address;
            wdata_q    <= request_data;
            if (misaligned || out_of_range) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              state_q      <= RESPOND;
            end else if (request_write && request_size[1]) begin
              ram_wdata_q <= request_data;
              ram_we_q    <= 1'b1;
              state_q     <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            ram_wdata_q <= merged_d;
            ram_we_q    <= 1'b1;
            state_q     <= WRITE;
          end else begin
            resp_data_q  <= load_value_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESPOND;
          end
        end
        WRITE: begin
          ram_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESPOND;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_data_q  <= 32'h0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign request_ready    = (state_q == IDLE);
  assign response_valid   = resp_valid_q;
  assign response_error   = resp_error_q;
  assign response_data    = resp_data_q;
  assign ram_address      = {addr_q[31:2], 2'b00};
  assign ram_input_data   = ram_wdata_q;
  // Gate with reset so a reset raised mid-WRITE blocks the negedge commit.
  assign ram_should_write = ram_we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word negedge-write RAM model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic        request_write = 1'b0;
  logic [1:0]  request_size = 2'b00;
  logic        request_unsigned = 1'b0;
  logic [31:0] request_address = 32'h0;
  logic [31:0] request_data = 32'h0;
  logic        response_valid;
  logic        response_error;
  logic [31:0] response_data;
  logic [31:0] ram_address;
  logic [31:0] ram_input_data;
  logic        ram_should_write;
  logic [31:0] ram_output_data;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  load_store_unit #(.SIZE_WORDS(64)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_size(request_size),
    .request_unsigned(request_unsigned), .request_address(request_address),
    .request_data(request_data),
    .response_valid(response_valid), .response_error(response_error),
    .response_data(response_data),
    .ram_address(ram_address), .ram_input_data(ram_input_data),
    .ram_should_write(ram_should_write), .ram_output_data(ram_output_data)
  );

  assign ram_output_data = mem[ram_address[7:2]];

  always @(negedge clock) begin
    if (ram_should_write) mem[ram_address[7:2]] <= ram_input_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request at a negedge and measure latency in cycles after acceptance.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] data,
                      input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                      input logic exp_we);
    int lat;
    logic we_seen;
    @(negedge clock);
    check({tag, ".ready"}, 32'(request_ready), 32'd1);
    request_write = wr; request_size = sz; request_unsigned = uns;
    request_address = addr; request_data = data; request_valid = 1'b1;
    @(negedge clock);
    request_valid = 1'b0;
    lat = 1;
    we_seen = ram_should_write;
    while (!response_valid && lat < 8) begin
      @(negedge clock);
      lat++;
      we_seen |= ram_should_write;
    end
    $display("%s: wr=%0b size=%0d uns=%0b addr=0x%08h data=0x%08h -> lat=%0d resp=0x%08h err=%0b",
             tag, wr, sz, uns, addr, data, lat, response_data, response_error);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, response_data, exp_data);
    check({tag, ".err"}, 32'(response_error), 32'(exp_err));
    check({tag, ".we"}, 32'(we_seen), 32'(exp_we));
    @(negedge clock);
    check({tag, ".pulse"}, 32'(response_valid), 32'd0);
  endtask

  initial begin
    int accepted;
    logic [9:0] ready_pat;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    #12;
    check("rst.ready", 32'(request_ready), 32'd1);
    check("rst.valid", 32'(response_valid), 32'd0);
    check("rst.err", 32'(response_error), 32'd0);
    check("rst.data", response_data, 32'h0);
    check("rst.we", 32'(ram_should_write), 32'd0);
    check("rst.addr", ram_address, 32'h0);
    check("rst.wdata", ram_input_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    xact("st_w8", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 0, 1);
    check("mem2.a", mem[2], 32'hDEADBEEF);
    xact("ld_w8", 0, 2'b10, 0, 32'h8, 32'h0, 2, 32'hDEADBEEF, 0, 0);
    xact("st_b9", 1, 2'b00, 0, 32'h9, 32'h0000005A, 3, 32'h0, 0, 1);
    check("mem2.b", mem[2], 32'hDEAD5AEF);
    xact("ld_bB_s", 0, 2'b00, 0, 32'hB, 32'h0, 2, 32'hFFFFFFDE, 0, 0);
    xact("ld_bB_u", 0, 2'b00, 1, 32'hB, 32'h0, 2, 32'h000000DE, 0, 0);
    xact("ld_b9_s", 0, 2'b00, 0, 32'h9, 32'h0, 2, 32'h0000005A, 0, 0);
    xact("st_hA", 1, 2'b01, 0, 32'hA, 32'h00008001, 3, 32'h0, 0, 1);
    check("mem2.c", mem[2], 32'h80015AEF);
    xact("ld_hA_s", 0, 2'b01, 0, 32'hA, 32'h0, 2, 32'hFFFF8001, 0, 0);
    xact("ld_hA_u", 0, 2'b01, 1, 32'hA, 32'h0, 2, 32'h00008001, 0, 0);
    xact("ld_h8_s", 0, 2'b01, 0, 32'h8, 32'h0, 2, 32'h00005AEF, 0, 0);
    xact("ld_sz3", 0, 2'b11, 0, 32'h8, 32'h0, 2, 32'h80015AEF, 0, 0);
    xact("ld_w6", 0, 2'b10, 0, 32'h6, 32'h0, 1, 32'h0, 1, 0);
    xact("st_w100", 1, 2'b10, 0, 32'h100, 32'h12345678, 1, 32'h0, 1, 0);
    xact("st_h3", 1, 2'b01, 0, 32'h3, 32'h0000FFFF, 1, 32'h0, 1, 0);
    xact("st_bFF", 1, 2'b00, 0, 32'hFF, 32'h000000AA, 3, 32'h0, 0, 1);
    check("mem63", mem[63], 32'hAA000000);
    check("mem0", mem[0], 32'h0);

    // Reset raised inside a WRITE cycle, before its negedge.
    mem[5] = 32'h11111111;
    @(negedge clock);
    request_write = 1'b1; request_size = 2'b10; request_unsigned = 1'b0;
    request_address = 32'h14; request_data = 32'hCAFEF00D; request_valid = 1'b1;
    @(posedge clock);
    #1 request_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check("rstw.we", 32'(ram_should_write), 32'd0);
    @(negedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rstw.noresp", 32'(response_valid), 32'd0);
    end
    check("rstw.ready", 32'(request_ready), 32'd1);
    check("rstw.mem5", mem[5], 32'h11111111);
    $display("rst_in_write: mem[5]=0x%08h ready=%0b", mem[5], request_ready);

    // request_valid held for 10 cycles with a word load.
    accepted = 0;
    ready_pat = 10'h0;
    @(negedge clock);
    request_write = 1'b0; request_size = 2'b10; request_address = 32'h8; request_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ready_pat[9 - i] = request_ready;
      if (request_ready) accepted++;
      @(negedge clock);
    end
    request_valid = 1'b0;
    $display("stream: accepted=%0d ready_pattern=%b", accepted, ready_pat);
    check("stream.count", 32'(accepted), 32'd4);
    check("stream.pattern", 32'(ready_pat), 32'(10'b1001001001));
    repeat (3) @(negedge clock);
    check("stream.idle", 32'(request_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SIZE_WORDS, 64, number of 32-bit words in the attached ram; word index >= SIZE_WORDS is an access fault.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: request_valid  input  1  CPU presents a memory request.
REQ-005 Port: request_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: request_write  input  1  1 = store, 0 = load.
REQ-007 Port: request_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 Port: request_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 Port: request_address  input  32  byte address.
REQ-010 Port: request_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port: response_valid  output  1  one-cycle completion pulse.
REQ-012 Port: response_error  output  1  completion was misaligned or out of range.
REQ-013 Port: response_data  output  32  extended load result; 0 for stores and errors.
REQ-014 Port: ram_address  output  32  byte address to ram, low two bits forced 0.
REQ-015 Port: ram_input_data  output  32  full word to write.
REQ-016 Port: ram_should_write  output  1  ram write enable; ram commits on the negedge inside the cycle.
REQ-017 Port: ram_output_data  input  32  combinational read data from ram at ram_address.

Function
REQ-018 States SHALL be IDLE, READ, WRITE, RESPOND; request_ready = 1 only in IDLE.
REQ-019 A request SHALL be accepted on a posedge with request_valid and request_ready both high; all request fields are latched at acceptance and held to completion.
REQ-020 request_valid while not in IDLE SHALL be ignored; no queuing.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or word index >= SIZE_WORDS SHALL go IDLE->RESPOND with response_error=1 and no ram write.
REQ-022 Load: IDLE->READ->RESPOND; in READ the selected lane is extracted from ram_output_data and registered at the next posedge.
REQ-023 Word store: IDLE->WRITE->RESPOND; ram_should_write=1 only during WRITE, with ram_input_data=request_data.
REQ-024 Byte/half store: IDLE->READ->WRITE->RESPOND; old word captured at end of READ, WRITE writes old word with only the addressed lane(s) replaced.
REQ-025 Lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1]*16.
REQ-026 RESPOND SHALL last exactly one cycle with response_valid=1, then return to IDLE; no backpressure on responses.
REQ-027 ram_address and ram_input_data SHALL be driven from registers, stable for the whole READ/WRITE cycle.
REQ-028 Latency from accepting edge to response_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-029 Outside RESPOND, response_valid, response_error and response_data SHALL be 0.

Reset
REQ-030 While reset is high: state IDLE, request_ready=1, response_valid=0, response_error=0, response_data=0, ram_should_write=0, ram_address=0, ram_input_data=0, latched request fields 0.
REQ-031 ram_should_write SHALL drop combinationally on reset assertion, so a reset raised before the negedge of a WRITE cycle suppresses the ram write.
REQ-032 An in-flight request SHALL be discarded on reset with no response.

Verification
REQ-033 Word store 0xDEADBEEF @0x8, then word load @0x8 -> response_data 0xDEADBEEF, response_valid 1 cycle, 2 cycles after each acceptance.
REQ-034 Byte store 0x5A @0x9 -> ram word 2 = 0xDEAD5AEF after 3 cycles; signed byte load @0xB -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-035 Half store 0x8001 @0xA -> word 0x80015AEF; signed half load @0xA -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-036 Word load @0x6 and word store @0x100 (SIZE_WORDS=64) -> response_error=1 after 1 cycle, response_data 0, ram_should_write never high.
REQ-037 Reset pulsed in WRITE cycle before negedge -> target word unchanged, no response_valid, request_ready=1 after release.
REQ-038 request_valid held high for 10 cycles with one word load -> exactly 4 requests accepted, request_ready high only in IDLE cycles.
